// File: rtl/tnoc_output_port_arbiter_pkg.sv
// Shared types for the output-port arbiter: NoC configuration, per-VC arbiter state
// and the round-robin pick helper.
package tnoc_output_port_arbiter_pkg;

    localparam int TNOC_MAX_INPUTS = 32;

    typedef struct packed {
        int unsigned virtual_channels;
    } tnoc_config;

    localparam tnoc_config TNOC_DEFAULT_CONFIG = '{virtual_channels: 32'd2};

    typedef enum logic [0:0] {
        TNOC_PORT_ARBITER_IDLE = 1'b0,
        TNOC_PORT_ARBITER_BUSY = 1'b1
    } tnoc_port_arbiter_state;

    // First set bit of mask at or after ptr, wrapping at n; returns one-hot (zero if mask empty).
    function automatic logic [TNOC_MAX_INPUTS-1:0] tnoc_rr_pick(
        input logic [TNOC_MAX_INPUTS-1:0] mask,
        input int unsigned                ptr,
        input int unsigned                n
    );
        logic [TNOC_MAX_INPUTS-1:0] onehot;
        logic                       found;
        int unsigned                idx;
        onehot = '0;
        found  = 1'b0;
        for (int unsigned i = 0; i < TNOC_MAX_INPUTS; i++) begin
            idx = ptr + i;
            if (idx >= n) begin
                idx = idx - n;
            end else begin
                idx = idx;
            end
            if ((i < n) && !found && mask[idx[4:0]]) begin
                onehot[idx[4:0]] = 1'b1;
                found            = 1'b1;
            end else begin
                found = found;
            end
        end
        return onehot;
    endfunction

endpackage

// File: rtl/tnoc_output_port_arbiter_if.sv
// Port-control handshake between the input ports' route selectors and one output-port
// arbiter; every field is indexed [input][virtual channel].
interface tnoc_port_control_if #(
    parameter int INPUTS   = 5,
    parameter int CHANNELS = 2
);
    logic [INPUTS-1:0][CHANNELS-1:0] request;
    logic [INPUTS-1:0][CHANNELS-1:0] free;
    logic [INPUTS-1:0][CHANNELS-1:0] start_of_packet;
    logic [INPUTS-1:0][CHANNELS-1:0] end_of_packet;
    logic [INPUTS-1:0][CHANNELS-1:0] grant;

    modport master (
        output request,
        output free,
        output start_of_packet,
        output end_of_packet,
        input  grant
    );

    modport slave (
        input  request,
        input  free,
        input  start_of_packet,
        input  end_of_packet,
        output grant
    );
endinterface

// File: rtl/tnoc_output_port_arbiter_chk.sv
// Protocol checks for the output-port arbiter: exclusive ownership and no stray tails.
module tnoc_output_port_arbiter_chk #(
    parameter int INPUTS   = 5,
    parameter int CHANNELS = 2
) (
    input logic                             clk,
    input logic                             rst_n,
    input logic [CHANNELS-1:0][INPUTS-1:0]  grant_col,
    input logic [CHANNELS-1:0][INPUTS-1:0]  request_col,
    input logic [CHANNELS-1:0][INPUTS-1:0]  sop_col,
    input logic [CHANNELS-1:0][INPUTS-1:0]  eop_col
);
    for (genvar v = 0; v < CHANNELS; v++) begin : g_vc
        a_onehot_grant : assert property (@(posedge clk) disable iff (!rst_n)
            $onehot0(grant_col[v]))
            else $error("arbiter: more than one owner on VC %0d", v);

        // A waiting single-flit head legitimately carries eop; any other eop must come from the owner.
        a_eop_owner : assert property (@(posedge clk) disable iff (!rst_n)
            ((eop_col[v] & ~grant_col[v] & ~(request_col[v] & sop_col[v])) == '0))
            else $error("arbiter: end_of_packet from a non-owner on VC %0d", v);
    end
endmodule

// File: rtl/tnoc_output_port_arbiter_rr.sv
// Single-VC packet-locked round-robin arbiter with optional stall watchdog
// (TNOC_PORT_ARBITER_TIMEOUT_EN).
module tnoc_round_robin_arbiter
    import tnoc_output_port_arbiter_pkg::*;
#(
    parameter int                INPUTS         = 5,
    parameter logic [INPUTS-1:0] ACTIVE_INPUTS  = {INPUTS{1'b1}},
    parameter int                TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [INPUTS-1:0] request,
    input  logic [INPUTS-1:0] free,
    input  logic [INPUTS-1:0] start_of_packet,
    input  logic [INPUTS-1:0] end_of_packet,
    output logic [INPUTS-1:0] grant,
    output logic              timeout_hit
);
    localparam int PTR_W = (INPUTS > 1) ? $clog2(INPUTS) : 1;

    tnoc_port_arbiter_state     state_r, state_s;
    logic [INPUTS-1:0]          grant_r, grant_s, cand_s, pick_s;
    logic [PTR_W-1:0]           ptr_r, ptr_s, win_s, ptr_nxt_s;
    logic [TNOC_MAX_INPUTS-1:0] pick_wide_s;
    logic                       pick_unused_s;
    logic                       release_s;

    // The current owner is never a candidate, so a tail cycle hands over to someone else.
    assign cand_s        = request & start_of_packet & ACTIVE_INPUTS & ~grant_r;
    assign pick_wide_s   = tnoc_rr_pick(TNOC_MAX_INPUTS'(cand_s), 32'(ptr_r), 32'(INPUTS));
    assign pick_s        = pick_wide_s[INPUTS-1:0];
    assign pick_unused_s = ^pick_wide_s;
    assign release_s     = (state_r == TNOC_PORT_ARBITER_BUSY) && (|(grant_r & end_of_packet));
    assign grant         = grant_r;

    // Winner index and the pointer position just past it
    always_comb begin
        win_s = '0;
        for (int i = 0; i < INPUTS; i++) begin
            win_s = pick_s[i] ? PTR_W'(i) : win_s;
        end
        ptr_nxt_s = (win_s == PTR_W'(INPUTS - 1)) ? '0 : win_s + PTR_W'(1);
    end

    // Next-state logic: lock on a head, release on the owner's tail with zero-bubble handover
    always_comb begin
        state_s = state_r;
        grant_s = grant_r;
        ptr_s   = ptr_r;
        case (state_r)
            TNOC_PORT_ARBITER_IDLE: begin
                if (|pick_s) begin
                    state_s = TNOC_PORT_ARBITER_BUSY;
                    grant_s = pick_s;
                    ptr_s   = ptr_nxt_s;
                end else begin
                    state_s = TNOC_PORT_ARBITER_IDLE;
                end
            end
            TNOC_PORT_ARBITER_BUSY: begin
                if (release_s && (|pick_s)) begin
                    grant_s = pick_s;
                    ptr_s   = ptr_nxt_s;
                end else if (release_s) begin
                    state_s = TNOC_PORT_ARBITER_IDLE;
                    grant_s = '0;
                end else begin
                    state_s = TNOC_PORT_ARBITER_BUSY;
                end
            end
            default: begin
                state_s = TNOC_PORT_ARBITER_IDLE;
                grant_s = '0;
            end
        endcase
    end

    // Arbiter state, lock and pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= TNOC_PORT_ARBITER_IDLE;
            grant_r <= '0;
            ptr_r   <= '0;
        end else begin
            state_r <= state_s;
            grant_r <= grant_s;
            ptr_r   <= ptr_s;
        end
    end

`ifdef TNOC_PORT_ARBITER_TIMEOUT_EN
    localparam int               CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] stall_r, stall_s;
    logic             owner_ok_s;

    assign owner_ok_s  = |(grant_r & request & free);
    assign timeout_hit = (stall_s == CNT_MAX);

    // Stall count advances only while an owner is neither moving flits nor releasing
    always_comb begin
        if ((state_r != TNOC_PORT_ARBITER_BUSY) || owner_ok_s || release_s) begin
            stall_s = '0;
        end else if (stall_r != CNT_MAX) begin
            stall_s = stall_r + CNT_W'(1);
        end else begin
            stall_s = stall_r;
        end
    end

    // Stall counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_r <= '0;
        end else begin
            stall_r <= stall_s;
        end
    end
`else
    logic wd_unused_s;
    assign wd_unused_s = ^{free, 32'(TIMEOUT_CYCLES)};
    assign timeout_hit = 1'b0;
`endif

endmodule

// File: rtl/tnoc_output_port_arbiter.sv
// Output-port arbiter: one round-robin packet arbiter per virtual channel.
// Optional sticky stall watchdog under TNOC_PORT_ARBITER_TIMEOUT_EN.
module tnoc_output_port_arbiter
    import tnoc_output_port_arbiter_pkg::*;
#(
    parameter tnoc_config        CONFIG         = TNOC_DEFAULT_CONFIG,
    parameter int                INPUTS         = 5,
    parameter logic [INPUTS-1:0] ACTIVE_INPUTS  = {INPUTS{1'b1}},
    parameter int                TIMEOUT_CYCLES = 1024,
    localparam int               CHANNELS       = int'(CONFIG.virtual_channels)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    tnoc_port_control_if.slave              port_control_if,
    output logic [CHANNELS-1:0][INPUTS-1:0] o_select,
    output logic                            o_timeout
);
    logic [CHANNELS-1:0][INPUTS-1:0] request_s, free_s, sop_s, eop_s, grant_s;
    logic [INPUTS-1:0][CHANNELS-1:0] grant_t_s;
    logic [CHANNELS-1:0]             timeout_hit_s;

    // Transpose [input][vc] interface arrays into per-VC columns and back
    always_comb begin
        request_s = '0;
        free_s    = '0;
        sop_s     = '0;
        eop_s     = '0;
        grant_t_s = '0;
        for (int v = 0; v < CHANNELS; v++) begin
            for (int p = 0; p < INPUTS; p++) begin
                request_s[v][p] = port_control_if.request[p][v];
                free_s[v][p]    = port_control_if.free[p][v];
                sop_s[v][p]     = port_control_if.start_of_packet[p][v];
                eop_s[v][p]     = port_control_if.end_of_packet[p][v];
                grant_t_s[p][v] = grant_s[v][p];
            end
        end
    end

    assign port_control_if.grant = grant_t_s;
    assign o_select              = grant_s;

    for (genvar v = 0; v < CHANNELS; v++) begin : g_vc
        tnoc_round_robin_arbiter #(
            .INPUTS         (INPUTS),
            .ACTIVE_INPUTS  (ACTIVE_INPUTS),
            .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
        ) u_arbiter (
            .clk             (clk),
            .rst_n           (rst_n),
            .request         (request_s[v]),
            .free            (free_s[v]),
            .start_of_packet (sop_s[v]),
            .end_of_packet   (eop_s[v]),
            .grant           (grant_s[v]),
            .timeout_hit     (timeout_hit_s[v])
        );
    end

    tnoc_output_port_arbiter_chk #(
        .INPUTS   (INPUTS),
        .CHANNELS (CHANNELS)
    ) u_chk (
        .clk         (clk),
        .rst_n       (rst_n),
        .grant_col   (grant_s),
        .request_col (request_s),
        .sop_col     (sop_s),
        .eop_col     (eop_s)
    );

`ifdef TNOC_PORT_ARBITER_TIMEOUT_EN
    logic timeout_r;

    // Sticky stall flag; only reset clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_r <= 1'b0;
        end else begin
            timeout_r <= timeout_r | (|timeout_hit_s);
        end
    end

    assign o_timeout = timeout_r;
`else
    logic hit_unused_s;
    assign hit_unused_s = |timeout_hit_s;
    assign o_timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_tnoc_output_port_arbiter.sv
// Bench for tnoc_output_port_arbiter: packet-level upstream model plus an ownership model
// compared every cycle, with directed scenarios and a randomized phase.
module tb_tnoc_output_port_arbiter;
    import tnoc_output_port_arbiter_pkg::*;

    localparam int NI  = 5;
    localparam int NV  = 2;
    localparam int TMO = 8;
    localparam logic [NI-1:0] ACTIVE = 5'b01111;
`ifdef TNOC_PORT_ARBITER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic [NV-1:0][NI-1:0] o_select;
    logic                  o_timeout;

    tnoc_port_control_if #(.INPUTS(NI), .CHANNELS(NV)) pc ();

    tnoc_output_port_arbiter #(
        .CONFIG         (TNOC_DEFAULT_CONFIG),
        .INPUTS         (NI),
        .ACTIVE_INPUTS  (ACTIVE),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .port_control_if (pc),
        .o_select        (o_select),
        .o_timeout       (o_timeout)
    );

    always #5 clk = ~clk;

    // reference ownership model
    int owner [NV];
    int ptr   [NV];
    int stall [NV];
    bit tmo;
    // upstream packet sources
    int len_q   [NI][NV];
    int sent_q  [NI][NV];
    bit bubble  [NI][NV];
    bit persist [NI][NV];
    bit rnd_mode;
    bit free_dir;
    logic [NI-1:0] active_v;

    int checks;
    int errors;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic clear_upstream();
        for (int p = 0; p < NI; p++) begin
            for (int v = 0; v < NV; v++) begin
                len_q[p][v]   = 0;
                sent_q[p][v]  = 0;
                bubble[p][v]  = 1'b0;
                persist[p][v] = 1'b0;
            end
        end
    endtask

    // Upstream: waiting packets present head (with eop if single-flit); owners stream flits.
    task automatic gen_inputs();
        logic r, s, e;
        for (int p = 0; p < NI; p++) begin
            for (int v = 0; v < NV; v++) begin
                r = 1'b0; s = 1'b0; e = 1'b0;
                if (persist[p][v] && len_q[p][v] == 0) len_q[p][v] = 1;
                if (rnd_mode && len_q[p][v] == 0 && $urandom_range(0, 3) == 0)
                    len_q[p][v] = int'($urandom_range(1, 5));
                if (owner[v] == p && len_q[p][v] > 0) begin
                    if (!(bubble[p][v] || (rnd_mode && $urandom_range(0, 4) == 0))) begin
                        r = 1'b1;
                        s = (sent_q[p][v] == 0);
                        e = (sent_q[p][v] == len_q[p][v] - 1);
                        sent_q[p][v]++;
                        if (e) begin
                            len_q[p][v]  = 0;
                            sent_q[p][v] = 0;
                        end
                    end
                end else if (len_q[p][v] > 0) begin
                    r = 1'b1;
                    s = 1'b1;
                    e = (len_q[p][v] == 1);
                end
                pc.request[p][v]         = r;
                pc.start_of_packet[p][v] = s;
                pc.end_of_packet[p][v]   = e;
                pc.free[p][v]            = rnd_mode ? ($urandom_range(0, 7) != 0) : free_dir;
            end
        end
    endtask

    // Ownership rules applied to the inputs sampled at the edge just taken.
    task automatic model_step();
        int o, win, c;
        bit rel;
        if (!rst_n) begin
            for (int v = 0; v < NV; v++) begin
                owner[v] = -1; ptr[v] = 0; stall[v] = 0;
            end
            tmo = 1'b0;
            return;
        end
        for (int v = 0; v < NV; v++) begin
            o   = owner[v];
            rel = (o >= 0) && pc.end_of_packet[o][v];
            if (o < 0 || rel || (pc.request[o][v] && pc.free[o][v])) begin
                stall[v] = 0;
            end else begin
                if (stall[v] < TMO) stall[v]++;
                if (stall[v] == TMO) tmo = 1'b1;
            end
            if (o < 0 || rel) begin
                win = -1;
                for (int k = 0; k < NI; k++) begin
                    c = (ptr[v] + k) % NI;
                    if (win < 0 && c != o && active_v[c] && pc.request[c][v] && pc.start_of_packet[c][v])
                        win = c;
                end
                owner[v] = win;
                if (win >= 0) ptr[v] = (win + 1) % NI;
            end
        end
    endtask

    task automatic compare_all();
        logic [NI-1:0] exp, gcol;
        for (int v = 0; v < NV; v++) begin
            exp = (owner[v] >= 0) ? (5'b00001 << owner[v]) : 5'b00000;
            for (int p = 0; p < NI; p++) gcol[p] = pc.grant[p][v];
            chk($sformatf("select_vc%0d", v), o_select[v], exp);
            chk($sformatf("grant_vc%0d", v), gcol, exp);
        end
        chk("timeout", 32'(o_timeout), TO_EN ? 32'(tmo) : 32'd0);
    endtask

    task automatic step();
        gen_inputs();
        @(posedge clk);
        #1;
        model_step();
        compare_all();
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        clear_upstream();
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    // Bounded wind-down: everything in flight finishes and every VC must end idle.
    task automatic drain();
        rnd_mode = 1'b0;
        free_dir = 1'b1;
        for (int p = 0; p < NI; p++) begin
            for (int v = 0; v < NV; v++) begin
                bubble[p][v]  = 1'b0;
                persist[p][v] = 1'b0;
                if (!active_v[p]) len_q[p][v] = 0;
            end
        end
        for (int i = 0; i < 80; i++) step();
        chk("drain_idle", 32'(o_select), 32'd0);
    endtask

    initial begin
        int exp3 [6];
        exp3     = '{0, 1, 3, 0, 1, 3};
        active_v = ACTIVE;
        checks   = 0;
        errors   = 0;
        rnd_mode = 1'b0;
        free_dir = 1'b1;
        rst_n    = 1'b0;
        for (int v = 0; v < NV; v++) begin
            owner[v] = -1; ptr[v] = 0; stall[v] = 0;
        end
        tmo = 1'b0;

        // reset values
        reset_dut();
        chk("rst_select", 32'(o_select), 32'd0);
        chk("rst_grant", 32'(pc.grant), 32'd0);
        chk("rst_timeout", 32'(o_timeout), 32'd0);

        // asynchronous reset mid-packet, then pointer back at 0
        len_q[2][0] = 10;
        repeat (3) step();
        chk("t1_owned", o_select[0], 5'b00100);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t1_async_grant", 32'(pc.grant), 32'd0);
        chk("t1_async_select", 32'(o_select), 32'd0);
        reset_dut();
        len_q[1][0] = 1;
        len_q[3][0] = 1;
        step();
        chk("t1_ptr_zero", o_select[0], 5'b00010);
        drain();

        // single requester, 4-flit packet
        len_q[2][0] = 4;
        step();
        chk("t2_grant", o_select[0], 5'b00100);
        repeat (3) step();
        chk("t2_hold", o_select[0], 5'b00100);
        step();
        chk("t2_release", o_select[0], 5'b00000);
        drain();

        // fairness with back-to-back single-flit packets
        persist[0][1] = 1'b1;
        persist[1][1] = 1'b1;
        persist[3][1] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("t3_rr%0d", i), o_select[1], 5'b00001 << exp3[i]);
        end
        drain();

        // lock through upstream bubbles; other VC independent
        len_q[3][0] = 6;
        repeat (3) step();
        bubble[3][0] = 1'b1;
        len_q[1][0]  = 2;
        len_q[1][1]  = 2;
        step();
        chk("t4_lock", o_select[0], 5'b01000);
        chk("t4_other_vc", o_select[1], 5'b00010);
        repeat (2) step();
        chk("t4_lock_bubble", o_select[0], 5'b01000);
        bubble[3][0] = 1'b0;
        repeat (3) step();
        chk("t4_before_tail", o_select[0], 5'b01000);
        step();
        chk("t4_handover", o_select[0], 5'b00010);
        drain();

        // masked input never wins
        len_q[4][0] = 2;
        repeat (5) step();
        chk("t5_masked", o_select[0], 5'b00000);
        len_q[0][0] = 1;
        step();
        chk("t5_unmasked", o_select[0], 5'b00001);
        drain();

        // watchdog
        reset_dut();
        free_dir    = 1'b0;
        len_q[2][0] = 30;
        repeat (8) step();
        chk("t6_before", 32'(o_timeout), 32'd0);
        step();
        chk("t6_set", 32'(o_timeout), 32'(TO_EN));
        free_dir = 1'b1;
        repeat (3) step();
        chk("t6_sticky", 32'(o_timeout), 32'(TO_EN));
        drain();

        // randomized traffic
        reset_dut();
        rnd_mode = 1'b1;
        repeat (3000) step();
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
